// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned OversampleDefault = 16;
    localparam int unsigned DataBitsDefault   = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 1
// so an idle-high line never looks like a falling edge after reset.
module sync2 (
    input  logic CLK,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/receiver.sv
// Oversampling UART receiver: start, DATA_BITS data bits MSB first, one stop bit.
// Valid / FrameErr are single-CLK pulses; DataOUT holds the last good byte.
module receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OversampleDefault,
    parameter int unsigned DATA_BITS  = DataBitsDefault
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 SampleTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] DataOUT,
    output logic                 Valid,
    output logic                 FrameErr,
    output logic                 Busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    uart_state_e          state_q;
    logic [TickW-1:0]     tick_q;
    logic [BitW-1:0]      bit_q;
    logic [DATA_BITS-1:0] shreg_q;

    sync2 u_sync2 (
        .CLK   (CLK),
        .Reset (Reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            rx_prev_q <= 1'b1;
            shreg_q   <= '0;
            DataOUT   <= '0;
            Valid     <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            if (SampleTick) begin
                // Tracked in every state so a line still low after a bad stop
                // bit cannot masquerade as a fresh falling edge.
                rx_prev_q <= rx_s;
                unique case (state_q)
                    StIdle: begin
                        if (rx_prev_q && !rx_s) begin
                            state_q <= StStart;
                            tick_q  <= '0;
                        end
                    end
                    StStart: begin
                        if (tick_q == HalfLast) begin
                            tick_q  <= '0;
                            bit_q   <= '0;
                            state_q <= rx_s ? StIdle : StData;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (tick_q == FullLast) begin
                            tick_q  <= '0;
                            shreg_q <= {shreg_q[DATA_BITS-2:0], rx_s};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == LastBit) begin
                                state_q <= StStop;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (tick_q == FullLast) begin
                            tick_q  <= '0;
                            state_q <= StIdle;
                            if (rx_s) begin
                                DataOUT <= shreg_q;
                                Valid   <= 1'b1;
                            end else begin
                                FrameErr <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign Busy = (state_q != StIdle);

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: frames are driven bit by bit, expected pulses
// are queued at drive time and matched by a monitor when Valid/FrameErr fire.
module tb_receiver;

    localparam int unsigned BitClk = 64;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       SampleTick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] DataOUT;
    logic       Valid;
    logic       FrameErr;
    logic       Busy;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_edge_cyc = 0;
    int         valid_cyc[$];
    exp_t       sb[$];
    bit [1:0]   div = 2'd0;

    receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .SampleTick (SampleTick),
        .rx         (rx),
        .DataOUT    (DataOUT),
        .Valid      (Valid),
        .FrameErr   (FrameErr),
        .Busy       (Busy)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // SampleTick every 4th CLK, changed away from the active edge.
    always @(negedge CLK) begin
        div = div + 2'd1;
        SampleTick = (div == 2'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every pulse must be expected, exclusive, and carry the right data.
    always @(negedge CLK) begin
        if (Valid === 1'b1 || FrameErr === 1'b1) begin
            exp_t e;
            chk("pulse_exclusive", 32'(Valid & FrameErr), 32'd0);
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(FrameErr), 32'(e.is_err));
                chk("pulse_data", 32'(DataOUT), 32'(e.data));
                if (Valid === 1'b1) valid_cyc.push_back(cyc);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        last_edge_cyc = cyc;
        hold(1'b0, BitClk);
        for (int i = 7; i >= 0; i--) hold(data[i], BitClk);
        hold(stop, BitClk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        repeat (5) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("rst_dataout", 32'(DataOUT), 32'h00);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_frameerr", 32'(FrameErr), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        hold(1'b1, 100);

        // Good frame 0xA5.
        sb.push_back('{is_err: 1'b0, data: 8'hA5});
        send_frame(8'hA5, 1'b1);
        drain(2000);
        lat = (valid_cyc.size() != 0) ? valid_cyc[$] - last_edge_cyc : -1;
        chk("a5_latency_in_range", 32'(lat >= 605 && lat <= 620), 32'd1);
        hold(1'b1, 10);
        chk("a5_busy_after", 32'(Busy), 32'd0);
        chk("a5_dataout", 32'(DataOUT), 32'hA5);

        // Short low glitch rejected at the mid-start sample.
        hold(1'b0, 12);
        chk("glitch_busy_start", 32'(Busy), 32'd1);
        hold(1'b0, 4);
        hold(1'b1, 32);
        chk("glitch_busy_cleared", 32'(Busy), 32'd0);
        hold(1'b1, 100);
        chk("glitch_dataout", 32'(DataOUT), 32'hA5);

        // Bad stop bit: FrameErr, DataOUT untouched, low line must not retrigger.
        sb.push_back('{is_err: 1'b1, data: 8'hA5});
        send_frame(8'h3C, 1'b0);
        drain(2000);
        chk("ferr_dataout", 32'(DataOUT), 32'hA5);
        hold(1'b0, 200);
        chk("low_hold_busy1", 32'(Busy), 32'd0);
        hold(1'b0, 200);
        chk("low_hold_busy2", 32'(Busy), 32'd0);
        hold(1'b1, 100);

        // Reset after three data bits of an aborted frame.
        hold(1'b0, BitClk);
        hold(1'b1, BitClk);
        hold(1'b0, BitClk);
        hold(1'b0, BitClk);
        rx = 1'b1;
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        hold(1'b1, 600);
        chk("abort_dataout", 32'(DataOUT), 32'h00);
        chk("abort_busy", 32'(Busy), 32'd0);
        sb.push_back('{is_err: 1'b0, data: 8'h81});
        send_frame(8'h81, 1'b1);
        drain(2000);
        chk("r81_dataout", 32'(DataOUT), 32'h81);

        // Back-to-back frames with a single stop bit between them.
        hold(1'b1, 100);
        sb.push_back('{is_err: 1'b0, data: 8'h00});
        sb.push_back('{is_err: 1'b0, data: 8'hFF});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain(2000);
        lat = (valid_cyc.size() >= 2) ? valid_cyc[$] - valid_cyc[$-1] : -1;
        chk("b2b_spacing", 32'(lat), 32'd640);
        chk("b2b_dataout", 32'(DataOUT), 32'hFF);
        hold(1'b1, 20);
        chk("b2b_busy_after", 32'(Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning SampleTick pulses per bit period (even, >=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-003 SHALL have port CLK  input  1  the single clock, all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port SampleTick  input  1  one-CLK strobe at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port DataOUT  output  DATA_BITS  last correctly framed byte.
REQ-008 SHALL have port Valid  output  1  one-CLK pulse marking a new DataOUT.
REQ-009 SHALL have port FrameErr  output  1  one-CLK pulse for a frame with stop bit 0.
REQ-010 SHALL have port Busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL use the frame format low start bit, DATA_BITS data bits MSB first, one high stop bit, with no parity.
REQ-013 SHALL advance the tick counter, bit counter and state only in CLK cycles where SampleTick=1.
REQ-014 SHALL implement states IDLE, START, DATA and STOP.
REQ-015 IDLE: SHALL go to START with tick counter 0 on a falling edge of rx_s (previous sampled 1, current 0); a line held low SHALL NOT re-trigger.
REQ-016 START: at tick count OVERSAMPLE/2-1, SHALL go to DATA with counters cleared if rx_s=0, else SHALL return to IDLE as a glitch with no output pulse.
REQ-017 DATA: at tick count OVERSAMPLE-1, SHALL shift rx_s into the LSB of the shift register (shreg <= {shreg[DATA_BITS-2:0], rx_s}), increment the bit counter and clear the tick counter.
REQ-018 DATA: after DATA_BITS bits are sampled, SHALL go to STOP.
REQ-019 STOP: at tick count OVERSAMPLE-1, if rx_s=1, SHALL load DataOUT from shreg and assert Valid.
REQ-020 STOP: at tick count OVERSAMPLE-1, if rx_s=0, SHALL assert FrameErr and leave DataOUT unchanged.
REQ-021 STOP: SHALL return to IDLE after the sample of REQ-019/REQ-020.
REQ-022 SHALL assert Valid and FrameErr for exactly the one CLK cycle after the stop-sample edge, never both in the same cycle.
REQ-023 DataOUT SHALL hold its value until the next valid frame; there is no consumer handshake, and an unread byte is overwritten.
REQ-024 SHALL accept back-to-back frames, starting start detection in the tick right after the STOP sample.
REQ-025 SHALL size the tick counter as $clog2(OVERSAMPLE) bits and the bit counter as $clog2(DATA_BITS+1) bits, with no wrap-around inside a bit period.

Reset
REQ-026 When Reset=1 on a CLK edge, SHALL set state to IDLE, clear both counters, set the synchronizer flops and the previous-rx flop to 1, clear shreg, and set DataOUT=0, Valid=0, FrameErr=0, Busy=0.
REQ-027 SHALL take Reset over SampleTick; reset mid-frame SHALL abandon the frame with no Valid and no FrameErr pulse.

Structure
REQ-028 SHALL place the state enum (IDLE, START, DATA, STOP) and default OVERSAMPLE/DATA_BITS constants in shared package uart_pkg, which the transmitter also uses.
REQ-029 SHALL instantiate the 2-flop synchronizer as sub-module sync2 (resets to 1); all other logic SHALL be in receiver.

Verification (OVERSAMPLE=16, SampleTick every 4th CLK, bit period 64 CLK)
REQ-030 Bench SHALL cover: frame 0xA5 (bits 1,0,1,0,0,1,0,1), stop 1 -> DataOUT=8'hA5 and one Valid pulse about 10 bit periods after the start edge; Busy low afterward.
REQ-031 Bench SHALL cover: rx low for 4 SampleTicks then high -> no Valid or FrameErr, Busy low again by tick 8.
REQ-032 Bench SHALL cover: 0xA5 then frame 0x3C with stop bit 0 -> one FrameErr pulse and DataOUT stays 8'hA5.
REQ-033 Bench SHALL cover: rx held low after a FrameErr -> no new START until rx returns high then falls.
REQ-034 Bench SHALL cover: Reset for 1 CLK after 3 data bits, then frame 0x81 -> no pulse for the aborted frame, then DataOUT=8'h81 and Valid.
REQ-035 Bench SHALL cover: back-to-back 0x00 then 0xFF with a single stop bit between -> two Valid pulses 640 CLK apart with DataOUT 8'h00 then 8'hFF.
